// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifq_pkg;

    localparam int unsigned IFQ_WIDTH = 32;
    localparam int unsigned IFQ_DEPTH = 4;
    localparam int unsigned IFQ_PTR_W = $clog2(IFQ_DEPTH) + 1;
    localparam logic [IFQ_WIDTH-1:0] IFQ_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [IFQ_WIDTH-1:0] pc;
        logic [IFQ_WIDTH-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with wrap-bit pointers and flush; head is read straight from storage.
module ifq_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_W-1:0]      pushData,
    input  logic                   pop,
    output logic [DATA_W-1:0]      headData,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = PTR_W - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic              full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[IDX_W-1:0]] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
        end
    end

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[PTR_W-1] != rdPtr[PTR_W-1]) &&
                      (wrPtr[IDX_W-1:0] == rdPtr[IDX_W-1:0]);
    assign count    = wrPtr - rdPtr;
    assign headData = mem[rdPtr[IDX_W-1:0]];

    // Credit logic upstream must never let a push land on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) assert (!(push && full && !pop));
    end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue feeding Fetch; redirects flush the queue and drop in-flight responses.
// Optional IFQ_BYPASS_EN presents a response to Fetch in its arrival cycle when the queue is empty.
module ifetch_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned      WIDTH    = IFQ_WIDTH,
    parameter int unsigned      DEPTH    = IFQ_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WIDTH-1:0]       imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [WIDTH-1:0]       imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [WIDTH-1:0]       redirect_pc,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output logic [WIDTH-1:0]       deq_instr,
    output logic [WIDTH-1:0]       deq_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned      PTR_W = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] ALIGN = WIDTH'(IFQ_ALIGN_MASK);

    logic [WIDTH-1:0] fetchPc;
    logic [PTR_W-1:0] dropCnt;
    logic [PTR_W-1:0] outstanding;
    logic [PTR_W-1:0] outNext;
    logic [PTR_W-1:0] qCount;
    logic [PTR_W:0]   inFlight;
    logic             qEmpty;
    logic             shEmpty;
    logic [WIDTH-1:0] rspPc;
    logic             reqFire;
    logic             rspFire;
    logic             rspKeep;
    logic             qPush;
    logic             qPop;
    ifq_entry_t       rspEntry;
    ifq_entry_t       headEntry;
    ifq_entry_t       deqEntry;

    // Credit: queued entries plus in-flight requests never exceed DEPTH.
    assign inFlight       = {1'b0, qCount} + {1'b0, outstanding};
    assign imem_req_valid = rst_n && (inFlight < (PTR_W+1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetchPc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign rspFire = imem_rsp_valid && !shEmpty;
    assign rspKeep = rspFire && !redirect_valid && (dropCnt == '0);
    assign outNext = outstanding + PTR_W'(reqFire) - PTR_W'(rspFire);

    always_comb begin
        rspEntry       = '0;
        rspEntry.pc    = rspPc;
        rspEntry.instr = imem_rsp_data;
    end

`ifdef IFQ_BYPASS_EN
    logic bypassHit;
    assign bypassHit = rspKeep && qEmpty;
    assign qPush     = rspKeep && !(bypassHit && deq_ready);
    assign deq_valid = !qEmpty || bypassHit;
    assign deqEntry  = qEmpty ? rspEntry : headEntry;
`else
    assign qPush     = rspKeep;
    assign deq_valid = !qEmpty;
    assign deqEntry  = headEntry;
`endif

    assign qPop      = !qEmpty && deq_ready;
    assign deq_instr = deq_valid ? deqEntry.instr : '0;
    assign deq_pc    = deq_valid ? deqEntry.pc : '0;
    assign occupancy = qCount;

    ifq_fifo #(.DATA_W($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (qPush),
        .pushData (rspEntry),
        .pop      (qPop),
        .headData (headEntry),
        .empty    (qEmpty),
        .count    (qCount)
    );

    // Shadow of issued addresses; its depth is the outstanding-request count.
    ifq_fifo #(.DATA_W(WIDTH), .DEPTH(DEPTH)) u_addrShadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push     (reqFire),
        .pushData (fetchPc),
        .pop      (rspFire),
        .headData (rspPc),
        .empty    (shEmpty),
        .count    (outstanding)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetchPc <= RESET_PC & ALIGN;
            dropCnt <= '0;
        end else if (redirect_valid) begin
            fetchPc <= redirect_pc & ALIGN;
            dropCnt <= outNext;
        end else begin
            if (reqFire) fetchPc <= (fetchPc + WIDTH'(4)) & ALIGN;
            if (rspFire && (dropCnt != '0)) dropCnt <= dropCnt - PTR_W'(1);
        end
    end

    // A response with nothing outstanding is a memory-side protocol error.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(imem_rsp_valid && shEmpty));
    end

endmodule
